// File: rtl/elegant_storage_pkg.sv
// Shared constants and types for the elegant_storage block.
//   DefaultWidth : default data word width in bits
//   DefaultCntW  : default width of the saturating write counter
//   data_t       : data word at the default width
package elegant_storage_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultCntW  = 8;

  typedef logic [DefaultWidth-1:0] data_t;

endpackage

// File: rtl/elegant_storage_parity.sv
// Even-parity generator and checker (purely combinational).
// Ports:
//   i_wr_data    : word about to be written; its parity is produced on o_wr_parity
//   i_rd_data    : word currently held in storage
//   i_rd_parity  : parity bit stored alongside i_rd_data
//   o_wr_parity  : XOR reduction of i_wr_data (even-parity bit)
//   o_parity_err : high when the stored word and stored parity bit disagree
module elegant_storage_parity #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [WIDTH-1:0] i_rd_data,
  input  logic             i_rd_parity,
  output logic             o_wr_parity,
  output logic             o_parity_err
);

  always_comb begin
    o_wr_parity  = ^i_wr_data;
    o_parity_err = (^i_rd_data) ^ i_rd_parity;
  end

endmodule

// File: rtl/elegant_storage.sv
// Single-word storage register with a valid flag and a saturating write counter.
// Optional feature: define ELEGANT_STORAGE_PARITY_EN to add a stored even-parity
// bit and the parity_err output.
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous active-high reset
//   write_enable : capture data_in at the rising edge when high
//   data_in      : value to store
//   data_out     : stored value, straight from the storage register
//   valid        : high once at least one write has completed since reset
//   write_count  : number of writes since reset, saturating at all-ones
//   parity_err   : (ELEGANT_STORAGE_PARITY_EN only) stored parity mismatch
module elegant_storage
  import elegant_storage_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic [CNT_W-1:0] write_count
`ifdef ELEGANT_STORAGE_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else if (write_enable) begin
      r_data  <= data_in;
      r_valid <= 1'b1;
      // Hold at all-ones instead of wrapping back to zero.
      if (r_count != {CNT_W{1'b1}}) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign data_out    = r_data;
  assign valid       = r_valid;
  assign write_count = r_count;

`ifdef ELEGANT_STORAGE_PARITY_EN
  logic r_parity;
  logic w_wr_parity;
  logic w_parity_err;

  elegant_storage_parity #(
    .WIDTH (WIDTH)
  ) u_parity (
    .i_wr_data    (data_in),
    .i_rd_data    (r_data),
    .i_rd_parity  (r_parity),
    .o_wr_parity  (w_wr_parity),
    .o_parity_err (w_parity_err)
  );

  // Parity is captured on the same edge as the data so the pair stays consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (write_enable) begin
      r_parity <= w_wr_parity;
    end
  end

  assign parity_err = w_parity_err;
`endif

endmodule

// File: tb/tb_elegant_storage.sv
// Directed self-checking bench for elegant_storage.
// u_dut uses the default widths; u_dut_sat uses CNT_W=2 to exercise saturation.
module tb_elegant_storage;
  import elegant_storage_pkg::*;

  logic       clk;
  logic       rst;
  logic       we;
  data_t      din;
  data_t      dout;
  logic       vld;
  logic [7:0] cnt;
  data_t      dout2;
  logic       vld2;
  logic [1:0] cnt2;
`ifdef ELEGANT_STORAGE_PARITY_EN
  logic       perr;
  logic       perr2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  elegant_storage u_dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (we),
    .data_in      (din),
    .data_out     (dout),
    .valid        (vld),
    .write_count  (cnt)
`ifdef ELEGANT_STORAGE_PARITY_EN
    ,
    .parity_err   (perr)
`endif
  );

  elegant_storage #(
    .WIDTH (8),
    .CNT_W (2)
  ) u_dut_sat (
    .clk          (clk),
    .rst          (rst),
    .write_enable (we),
    .data_in      (din),
    .data_out     (dout2),
    .valid        (vld2),
    .write_count  (cnt2)
`ifdef ELEGANT_STORAGE_PARITY_EN
    ,
    .parity_err   (perr2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_parity();
`ifdef ELEGANT_STORAGE_PARITY_EN
    check("parity_err", 64'(perr), 64'd0);
    check("parity_err_sat", 64'(perr2), 64'd0);
`endif
  endtask

  // Write d on the next rising edge, then wiggle data_in before the next negedge.
  task automatic do_write(input data_t d);
    @(negedge clk);
    we  = 1'b1;
    din = d;
    @(posedge clk);
    #1;
    din = ~d;
    check_parity();
  endtask

  initial begin
    rst = 1'b1;
    we  = 1'b1;
    din = 8'hFF;

    // Writes ignored while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 64'(dout), 64'h00);
    check("rst_valid", 64'(vld), 64'd0);
    check("rst_count", 64'(cnt), 64'd0);
    check("rst_count_sat", 64'(cnt2), 64'd0);
    check_parity();

    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;

    // data_out must not follow data_in/write_enable combinationally.
    @(negedge clk);
    we  = 1'b1;
    din = 8'h55;
    #1;
    check("no_comb_path", 64'(dout), 64'h00);
    @(posedge clk);
    #1;
    check("wr55_data", 64'(dout), 64'h55);
    check("wr55_valid", 64'(vld), 64'd1);
    check("wr55_count", 64'(cnt), 64'd1);

    // Hold for 3 edges; a write_enable pulse between edges is ignored.
    @(negedge clk);
    we  = 1'b0;
    din = 8'hAA;
    #1 we = 1'b1;
    #1 we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_data", 64'(dout), 64'h55);
    check("hold_count", 64'(cnt), 64'd1);

    // Boundaries after a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    do_write(8'hFF);
    check("bnd_ff", 64'(dout), 64'hFF);
    do_write(8'h00);
    check("bnd_00", 64'(dout), 64'h00);
    check("bnd_valid", 64'(vld), 64'd1);
    check("bnd_count", 64'(cnt), 64'd2);

    // Back-to-back writes on consecutive edges.
    do_write(8'h12);
    check("b2b_12", 64'(dout), 64'h12);
    do_write(8'h34);
    check("b2b_34", 64'(dout), 64'h34);
    do_write(8'h56);
    check("b2b_56", 64'(dout), 64'h56);
    check("b2b_count", 64'(cnt), 64'd5);
    @(negedge clk);
    we = 1'b0;

    // Asynchronous reset between edges.
    do_write(8'hAA);
    check("pre_arst", 64'(dout), 64'hAA);
    @(negedge clk);
    we = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_data", 64'(dout), 64'h00);
    check("arst_valid", 64'(vld), 64'd0);
    check("arst_count", 64'(cnt), 64'd0);
    check_parity();
    #1 rst = 1'b0;
    do_write(8'h34);
    check("post_arst_data", 64'(dout), 64'h34);
    check("post_arst_count", 64'(cnt), 64'd1);

    // Saturation of the 2-bit counter over 5 writes.
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      do_write(8'(i * 8'h11));
      check("sat_count2", 64'(cnt2), (i > 3) ? 64'd3 : 64'(i));
      check("sat_count8", 64'(cnt), 64'(i));
      check("sat_data2", 64'(dout2), 64'(i * 8'h11));
    end
    @(negedge clk);
    we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sat_hold", 64'(cnt2), 64'd3);
    check_parity();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
